// File: rtl/vga_pattern_writer_if.sv
// rtl/vga_pattern_writer_if.sv - character-write bus between the pattern writer and the vga core
//   write_char        : glyph code
//   write_char_pos    : linear cell address (row*COLS + col)
//   write_char_strobe : one-cycle write qualifier
//   master : pattern writer side, slave : vga core side
interface vga_pattern_writer_if #(
    parameter int CHAR_W = 8,
    parameter int POS_W  = 11
);
    logic [CHAR_W-1:0] write_char;
    logic [POS_W-1:0]  write_char_pos;
    logic              write_char_strobe;

    modport master (
        output write_char,
        output write_char_pos,
        output write_char_strobe
    );

    modport slave (
        input write_char,
        input write_char_pos,
        input write_char_strobe
    );
endinterface

// File: rtl/vga_pattern_writer.sv
// rtl/vga_pattern_writer.sv - test-pattern generator for the vga character-write port
//   CLK, reset : clock, synchronous active-high reset
//   enable     : run request, low forces IDLE
//   mode       : 0 SWEEP, 1 BURST, 2 CHECKER, 3 HOLD
//   wr         : character-write bus (master)
//   frame_done : one-cycle pulse with the strobe of the last cell
//   busy       : high in RUN or WAIT
//   VGA_PATTERN_CHECKER_EN : builds CHECKER mode; otherwise mode 2 acts as HOLD
module vga_pattern_writer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 24,
    parameter int TICK_DIV   = 40000000,
    parameter int GLYPHS     = 5,
    parameter int GLYPH_BASE = 0,
    parameter int CHAR_W     = 8,
    parameter int POS_W      = 11
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    vga_pattern_writer_if.master wr,
    output logic                 frame_done,
    output logic                 busy
);
    localparam int GW = (GLYPHS > 1) ? $clog2(GLYPHS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [GW-1:0]     G_LAST = GW'(GLYPHS - 1);
    localparam logic [CW-1:0]     C_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0]     R_LAST = RW'(ROWS - 1);
    localparam logic [TW-1:0]     T_LAST = TW'(TICK_DIV - 1);
    localparam logic [CHAR_W-1:0] BASE   = CHAR_W'(GLYPH_BASE);

    localparam logic [1:0] M_SWEEP = 2'd0;
    localparam logic [1:0] M_BURST = 2'd1;
`ifdef VGA_PATTERN_CHECKER_EN
    localparam logic [1:0] M_CHECKER = 2'd2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cur_mode_q, cur_mode_d;
    logic [GW-1:0]     glyph_q, glyph_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [CHAR_W-1:0] char_q, char_d;
    logic [POS_W-1:0]  wpos_q, wpos_d;
    logic              strobe_q, strobe_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
`ifdef VGA_PATTERN_CHECKER_EN
    // rbase = (row + glyph) mod GLYPHS, chk = (col + row + glyph) mod GLYPHS,
    // both stepped incrementally so no divider is needed.
    logic [GW-1:0]     rbase_q, rbase_d;
    logic [GW-1:0]     chk_q, chk_d;
`endif

    logic              tick;
    logic              last_cell;
    logic              mode_ok;
    logic [CHAR_W-1:0] cell_char;

    function automatic logic [GW-1:0] glyph_inc(input logic [GW-1:0] g);
        return (g == G_LAST) ? '0 : g + 1'b1;
    endfunction

    assign tick      = (tick_q == T_LAST);
    assign last_cell = (col_q == C_LAST) && (row_q == R_LAST);

`ifdef VGA_PATTERN_CHECKER_EN
    assign mode_ok   = (mode != 2'd3);
    assign cell_char = (cur_mode_q == M_CHECKER) ? BASE + CHAR_W'(chk_q)
                                                 : BASE + CHAR_W'(glyph_q);
`else
    assign mode_ok   = (mode == M_SWEEP) || (mode == M_BURST);
    assign cell_char = BASE + CHAR_W'(glyph_q);
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_mode_q   <= M_SWEEP;
            glyph_q      <= '0;
            pos_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            tick_q       <= '0;
            char_q       <= '0;
            wpos_q       <= '0;
            strobe_q     <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef VGA_PATTERN_CHECKER_EN
            rbase_q      <= '0;
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cur_mode_q   <= cur_mode_d;
            glyph_q      <= glyph_d;
            pos_q        <= pos_d;
            col_q        <= col_d;
            row_q        <= row_d;
            tick_q       <= tick_d;
            char_q       <= char_d;
            wpos_q       <= wpos_d;
            strobe_q     <= strobe_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
`ifdef VGA_PATTERN_CHECKER_EN
            rbase_q      <= rbase_d;
            chk_q        <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_mode_d   = cur_mode_q;
        glyph_d      = glyph_q;
        pos_d        = pos_q;
        col_d        = col_q;
        row_d        = row_q;
        tick_d       = tick_q;
        char_d       = char_q;
        wpos_d       = wpos_q;
        strobe_d     = 1'b0;
        frame_done_d = 1'b0;
`ifdef VGA_PATTERN_CHECKER_EN
        rbase_d      = rbase_q;
        chk_d        = chk_q;
`endif

        case (state_q)
            S_IDLE: begin
                pos_d  = '0;
                col_d  = '0;
                row_d  = '0;
                tick_d = '0;
                if (enable && mode_ok) begin
                    state_d    = S_RUN;
                    cur_mode_d = mode;
`ifdef VGA_PATTERN_CHECKER_EN
                    rbase_d    = glyph_q;
                    chk_d      = glyph_q;
`endif
                end
            end

            S_RUN: begin
                if (!enable) begin
                    // Abandon the partial frame: no write, glyph kept.
                    state_d = S_IDLE;
                    pos_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    tick_d  = '0;
                end else begin
                    tick_d = tick ? '0 : tick_q + 1'b1;
                    if (cur_mode_q != M_SWEEP || tick) begin
                        strobe_d = 1'b1;
                        char_d   = cell_char;
                        wpos_d   = pos_q;
                        if (last_cell) begin
                            frame_done_d = 1'b1;
                            glyph_d      = glyph_inc(glyph_q);
                            pos_d        = '0;
                            col_d        = '0;
                            row_d        = '0;
`ifdef VGA_PATTERN_CHECKER_EN
                            rbase_d      = glyph_inc(glyph_q);
                            chk_d        = glyph_inc(glyph_q);
`endif
                            if (cur_mode_q != M_SWEEP) begin
                                tick_d  = '0;
                                state_d = S_WAIT;
                            end
                        end else begin
                            pos_d = pos_q + 1'b1;
                            if (col_q == C_LAST) begin
                                col_d   = '0;
                                row_d   = row_q + 1'b1;
`ifdef VGA_PATTERN_CHECKER_EN
                                rbase_d = glyph_inc(rbase_q);
                                chk_d   = glyph_inc(rbase_q);
`endif
                            end else begin
                                col_d   = col_q + 1'b1;
`ifdef VGA_PATTERN_CHECKER_EN
                                chk_d   = glyph_inc(chk_q);
`endif
                            end
                        end
                    end
                end
            end

            S_WAIT: begin
                if (!enable || tick) begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign wr.write_char        = char_q;
    assign wr.write_char_pos    = wpos_q;
    assign wr.write_char_strobe = strobe_q;
    assign frame_done           = frame_done_q;
    assign busy                 = busy_q;
endmodule

// File: tb/tb_vga_pattern_writer.sv
// tb/tb_vga_pattern_writer.sv - self-checking bench for vga_pattern_writer
module tb_vga_pattern_writer;
    localparam int COLS       = 4;
    localparam int ROWS       = 2;
    localparam int TICK_DIV   = 3;
    localparam int GLYPHS     = 3;
    localparam int GLYPH_BASE = 'h41;
    localparam int CHAR_W     = 8;
    localparam int POS_W      = 11;
    localparam int CELLS      = COLS * ROWS;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] mode   = 2'd0;
    logic       frame_done;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [POS_W-1:0]  pos;
        logic [CHAR_W-1:0] ch;
        logic              fd;
        int                gap;
    } exp_t;

    exp_t sb[$];

    vga_pattern_writer_if #(.CHAR_W(CHAR_W), .POS_W(POS_W)) wr_if ();

    vga_pattern_writer #(
        .COLS(COLS), .ROWS(ROWS), .TICK_DIV(TICK_DIV), .GLYPHS(GLYPHS),
        .GLYPH_BASE(GLYPH_BASE), .CHAR_W(CHAR_W), .POS_W(POS_W)
    ) dut (
        .CLK(clk),
        .reset(reset),
        .enable(enable),
        .mode(mode),
        .wr(wr_if),
        .frame_done(frame_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, failures so far %0d", fails);
        $fatal(1);
    end

    function automatic exp_t mk(input int pos, input int ch, input bit fd, input int gap);
        exp_t e;
        e.pos = POS_W'(pos);
        e.ch  = CHAR_W'(ch);
        e.fd  = fd;
        e.gap = gap;
        return e;
    endfunction

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        mode   = 2'd3;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        @(negedge clk);
    endtask

    // Waits for the next strobe; reports how many negedges it took.
    task automatic wait_strobe(input int budget, output int waited, output bit seen);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            if (wr_if.write_char_strobe) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        mode   = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_if.write_char_strobe !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: strobe=%b frame_done=%b busy=%b, want 0 0 0",
                     wr_if.write_char_strobe, frame_done, busy);
        end
        checks++;
        if (wr_if.write_char !== '0 || wr_if.write_char_pos !== '0) begin
            fails++;
            $display("FAIL reset_data: char=%h pos=%0d, want 0 0", wr_if.write_char, wr_if.write_char_pos);
        end
        mode  = 2'd3;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (wr_if.write_char_strobe !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL hold_mode cycle %0d: strobe=%b busy=%b, want 0 0", i, wr_if.write_char_strobe, busy);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        int   w;
        bit   s;
        do_reset();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < CELLS; i++)
                sb.push_back(mk(i, GLYPH_BASE + (f % GLYPHS), i == CELLS - 1,
                                (f == 0 && i == 0) ? TICK_DIV + 1 : TICK_DIV));
        mode   = 2'd0;
        enable = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_strobe(e.gap + 2, w, s);
            checks++;
            if (!s || w != e.gap || wr_if.write_char_pos !== e.pos || wr_if.write_char !== e.ch || frame_done !== e.fd) begin
                fails++;
                $display("FAIL sweep: seen=%0d gap=%0d pos=%0d char=%h fd=%b, want gap=%0d pos=%0d char=%h fd=%b",
                         s, w, wr_if.write_char_pos, wr_if.write_char, frame_done, e.gap, e.pos, e.ch, e.fd);
            end
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_if.write_char_strobe !== 1'b0) begin
            fails++;
            $display("FAIL sweep_stop: busy=%b strobe=%b, want 0 0", busy, wr_if.write_char_strobe);
        end
    endtask

    task automatic test_burst();
        exp_t e;
        int   w;
        bit   s;
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < CELLS; i++)
                sb.push_back(mk(i, GLYPH_BASE + f, i == CELLS - 1,
                                (i != 0) ? 1 : (f == 0) ? 2 : TICK_DIV + 2));
        mode   = 2'd1;
        enable = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_strobe(e.gap + 2, w, s);
            checks++;
            if (!s || w != e.gap || wr_if.write_char_pos !== e.pos || wr_if.write_char !== e.ch || frame_done !== e.fd) begin
                fails++;
                $display("FAIL burst: seen=%0d gap=%0d pos=%0d char=%h fd=%b, want gap=%0d pos=%0d char=%h fd=%b",
                         s, w, wr_if.write_char_pos, wr_if.write_char, frame_done, e.gap, e.pos, e.ch, e.fd);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_if.write_char_strobe !== 1'b0) begin
            fails++;
            $display("FAIL burst_wait: busy=%b strobe=%b, want 1 0", busy, wr_if.write_char_strobe);
        end
        enable = 1'b0;
    endtask

    task automatic test_checker();
`ifdef VGA_PATTERN_CHECKER_EN
        exp_t e;
        int   w;
        bit   s;
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < CELLS; i++)
                sb.push_back(mk(i, GLYPH_BASE + ((i % COLS) + (i / COLS) + f) % GLYPHS, i == CELLS - 1,
                                (i != 0) ? 1 : (f == 0) ? 2 : TICK_DIV + 2));
        mode   = 2'd2;
        enable = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_strobe(e.gap + 2, w, s);
            checks++;
            if (!s || w != e.gap || wr_if.write_char_pos !== e.pos || wr_if.write_char !== e.ch || frame_done !== e.fd) begin
                fails++;
                $display("FAIL checker: seen=%0d gap=%0d pos=%0d char=%h fd=%b, want gap=%0d pos=%0d char=%h fd=%b",
                         s, w, wr_if.write_char_pos, wr_if.write_char, frame_done, e.gap, e.pos, e.ch, e.fd);
            end
        end
        enable = 1'b0;
`else
        int strobes;
        int busies;
        do_reset();
        strobes = 0;
        busies  = 0;
        mode    = 2'd2;
        enable  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (wr_if.write_char_strobe) strobes++;
            if (busy) busies++;
        end
        checks++;
        if (strobes != 0 || busies != 0) begin
            fails++;
            $display("FAIL checker_off: strobes=%0d busy_cycles=%0d, want 0 0", strobes, busies);
        end
        enable = 1'b0;
`endif
    endtask

    task automatic test_abort();
        exp_t e;
        int   w;
        bit   s;
        int   stray;
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back(mk(i, GLYPH_BASE, 1'b0, (i == 0) ? 2 : 1));
        mode   = 2'd1;
        enable = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_strobe(e.gap + 2, w, s);
            checks++;
            if (!s || w != e.gap || wr_if.write_char_pos !== e.pos || wr_if.write_char !== e.ch || frame_done !== e.fd) begin
                fails++;
                $display("FAIL abort_pre: seen=%0d gap=%0d pos=%0d char=%h fd=%b, want gap=%0d pos=%0d char=%h fd=%b",
                         s, w, wr_if.write_char_pos, wr_if.write_char, frame_done, e.gap, e.pos, e.ch, e.fd);
            end
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_if.write_char_strobe !== 1'b0 || frame_done !== 1'b0 || wr_if.write_char_pos !== POS_W'(3)) begin
            fails++;
            $display("FAIL abort_suppress: strobe=%b fd=%b pos=%0d, want 0 0 3",
                     wr_if.write_char_strobe, frame_done, wr_if.write_char_pos);
        end
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_if.write_char_strobe || frame_done || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            fails++;
            $display("FAIL abort_idle: active cycles=%0d, want 0", stray);
        end
        for (int i = 0; i < CELLS; i++) sb.push_back(mk(i, GLYPH_BASE, i == CELLS - 1, (i == 0) ? 2 : 1));
        enable = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_strobe(e.gap + 2, w, s);
            checks++;
            if (!s || w != e.gap || wr_if.write_char_pos !== e.pos || wr_if.write_char !== e.ch || frame_done !== e.fd) begin
                fails++;
                $display("FAIL abort_restart: seen=%0d gap=%0d pos=%0d char=%h fd=%b, want gap=%0d pos=%0d char=%h fd=%b",
                         s, w, wr_if.write_char_pos, wr_if.write_char, frame_done, e.gap, e.pos, e.ch, e.fd);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_mode_switch();
        exp_t e;
        int   w;
        bit   s;
        int   n;
        do_reset();
        for (int i = 0; i < CELLS; i++) sb.push_back(mk(i, GLYPH_BASE, i == CELLS - 1, (i == 0) ? 2 : 1));
        for (int i = 0; i < CELLS; i++)
            sb.push_back(mk(i, GLYPH_BASE + 1, i == CELLS - 1, (i == 0) ? 2 * TICK_DIV + 1 : TICK_DIV));
        mode   = 2'd1;
        enable = 1'b1;
        n      = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_strobe(e.gap + 2, w, s);
            n++;
            if (n == 3) mode = 2'd0;
            checks++;
            if (!s || w != e.gap || wr_if.write_char_pos !== e.pos || wr_if.write_char !== e.ch || frame_done !== e.fd) begin
                fails++;
                $display("FAIL mode_switch #%0d: seen=%0d gap=%0d pos=%0d char=%h fd=%b, want gap=%0d pos=%0d char=%h fd=%b",
                         n, s, w, wr_if.write_char_pos, wr_if.write_char, frame_done, e.gap, e.pos, e.ch, e.fd);
            end
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_burst();
        test_checker();
        test_abort();
        test_mode_switch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
